mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 34 +++
 rtl/mem_align.sv | 67 ++++++
 rtl/mem_stage.sv | 146 ++++++++++++++
 tb/tb_mem_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: LSU op codes, access-size codes,
// FSM state encoding and the byte-enable mask for each access size.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    LSU_NONE  = 2'd0,
    LSU_LOAD  = 2'd1,
    LSU_STORE = 2'd2
  } lsu_op_e;

  // Access sizes carried in the low two bits of ex_size (funct3 style).
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    HOLD
  } state_e;

  // Byte-enable pattern of an access of the given size at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Lane steering for the memory stage: store byte enables and lane-replicated
// store data, plus load lane extraction with sign/zero extension.
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB  = XLEN / 8,
  localparam int OW  = $clog2(NB)
) (
  input  logic [1:0]      st_size,
  input  logic [OW-1:0]   st_off,
  input  logic [XLEN-1:0] st_data,
  output logic [NB-1:0]   st_be,
  output logic [XLEN-1:0] st_wdata,
  input  logic [1:0]      ld_size,
  input  logic            ld_unsigned,
  input  logic [OW-1:0]   ld_off,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]      mask8;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic            sign;

  // Store side: size mask moved to the addressed lane, data copied into every lane.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    st_wdata = '0;
    mask8    = size_mask(st_size);
    st_be    = mask8[NB-1:0] << st_off;
    for (int i = 0; i < NB; i++) begin
      case (st_size)
        SZ_B:    st_wdata[i*8 +: 8] = st_data[7:0];
        SZ_H:    st_wdata[i*8 +: 8] = st_data[(i % 2)*8 +: 8];
        SZ_W:    st_wdata[i*8 +: 8] = st_data[(i % 4)*8 +: 8];
        default: st_wdata[i*8 +: 8] = st_data[(i % 8)*8 +: 8];
      endcase
    end
  end

  // Load side: bring the addressed lane down to bit 0, then extend above its top bit.
  always_comb begin
    shifted = ld_rdata >> {ld_off, 3'b000};
    case (ld_size)
      SZ_B: begin
        sign = shifted[7];
        keep = XLEN'(8'hFF);
      end
      SZ_H: begin
        sign = shifted[15];
        keep = XLEN'(16'hFFFF);
      end
      SZ_W: begin
        sign = shifted[31];
        keep = XLEN'(32'hFFFF_FFFF);
      end
      default: begin
        sign = shifted[XLEN-1];
        keep = '1;
      end
    endcase
    ld_data = (shifted & keep) | (~keep & {XLEN{sign & ~ld_unsigned}});
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: accepts one op from execute, runs at most one data
// memory transaction, and holds the result for writeback until accepted.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [XLEN-1:0]     ex_alu_res,
  input  logic [XLEN-1:0]     ex_wdata,
  input  logic [REG_AW-1:0]   ex_rd,
  input  logic [1:0]          ex_lsu_op,
  input  logic [2:0]          ex_size,
  output logic                dmem_req_valid,
  input  logic                dmem_req_ready,
  output logic [XLEN-1:0]     dmem_addr,
  output logic                dmem_we,
  output logic [XLEN/8-1:0]   dmem_be,
  output logic [XLEN-1:0]     dmem_wdata,
  input  logic                dmem_rsp_valid,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [REG_AW-1:0]   wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                wb_rf_we,
  output logic                wb_misalign
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  state_e              state, state_nx;
  logic                xfer, is_mem, is_store, ex_misalign, mem_go;
  logic [XLEN-1:0]     addr_q, wdata_q, wb_data_q, ld_data, st_wdata;
  logic [NB-1:0]       be_q, st_be;
  logic [OW-1:0]       off_q;
  logic [1:0]          size_q;
  logic                uns_q, we_q, wb_rf_we_q, wb_mis_q;
  logic [REG_AW-1:0]   rd_q;

  assign ex_ready = (state == IDLE) || ((state == HOLD) && wb_ready);
  assign xfer     = ex_valid && ex_ready;
  assign is_store = (ex_lsu_op == LSU_STORE);
  assign is_mem   = (ex_lsu_op == LSU_LOAD) || is_store;
  assign mem_go   = is_mem && !ex_misalign;

  // Alignment rule per access size; a dword access is illegal on a 32-bit bus.
  always_comb begin
    case (ex_size[1:0])
      SZ_B:    ex_misalign = 1'b0;
      SZ_H:    ex_misalign = ex_alu_res[0];
      SZ_W:    ex_misalign = |ex_alu_res[1:0];
      default: ex_misalign = (XLEN == 32) || (|ex_alu_res[2:0]);
    endcase
  end

  mem_align #(.XLEN(XLEN)) u_align (
    .st_size     (ex_size[1:0]),
    .st_off      (ex_alu_res[OW-1:0]),
    .st_data     (ex_wdata),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_off      (off_q),
    .ld_rdata    (dmem_rdata),
    .ld_data     (ld_data)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; a HOLD that hands off and accepts in the same cycle avoids a bubble.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (xfer) state_nx = mem_go ? REQ : HOLD;
      REQ:      if (dmem_req_ready) state_nx = WAIT_RSP;
      WAIT_RSP: if (dmem_rsp_valid) state_nx = HOLD;
      HOLD: begin
        if (xfer)          state_nx = mem_go ? REQ : HOLD;
        else if (wb_ready) state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  // Request and result registers: captured on transfer, result updated on response.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: these are a handful of flops, not a memory array, so all of them get a reset value.
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      wb_data_q  <= '0;
      wb_rf_we_q <= 1'b0;
      wb_mis_q   <= 1'b0;
    end else if (xfer) begin
      rd_q <= ex_rd;
      if (mem_go) begin
        addr_q  <= {ex_alu_res[XLEN-1:OW], {OW{1'b0}}};
        wdata_q <= st_wdata;
        be_q    <= st_be;
        we_q    <= is_store;
        off_q   <= ex_alu_res[OW-1:0];
        size_q  <= ex_size[1:0];
        uns_q   <= ex_size[2];
      end else begin
        // Plain ALU result, or the faulting address for a misaligned access.
        wb_data_q  <= ex_alu_res;
        wb_rf_we_q <= !is_mem && (ex_rd != '0);
        wb_mis_q   <= is_mem;
      end
    end else if ((state == WAIT_RSP) && dmem_rsp_valid) begin
      wb_data_q  <= we_q ? '0 : ld_data;
      wb_rf_we_q <= !we_q && (rd_q != '0);
      wb_mis_q   <= 1'b0;
    end
  end

  assign dmem_req_valid = (state == REQ);
  assign dmem_addr      = addr_q;
  assign dmem_we        = we_q;
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;
  assign wb_valid       = (state == HOLD);
  assign wb_rd          = rd_q;
  assign wb_data        = wb_data_q;
  assign wb_rf_we       = wb_rf_we_q;
  assign wb_misalign    = wb_mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage (XLEN=32): a byte-memory reference model
// predicts bus requests and writeback results; monitors compare as they appear.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              ex_valid, ex_ready;
  logic [XLEN-1:0]   ex_alu_res, ex_wdata;
  logic [REG_AW-1:0] ex_rd;
  logic [1:0]        ex_lsu_op;
  logic [2:0]        ex_size;
  logic              dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [XLEN-1:0]   dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]        dmem_be;
  logic              wb_valid, wb_ready, wb_rf_we, wb_misalign;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  mem_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_res(ex_alu_res),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd), .ex_lsu_op(ex_lsu_op), .ex_size(ex_size),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_rf_we(wb_rf_we), .wb_misalign(wb_misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic        rf_we;
    logic        mis;
    int          lat;
    int          xc;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];

  logic [7:0] ref_mem [int];
  logic [7:0] bus_mem [int];

  int n_cmp = 0, n_fail = 0;
  bit rand_mode = 0;
  int stall_req_cfg = 0, rsp_dly_cfg = 0, stall_wb_cfg = 0;
  int req_stall = 0, wb_stall = 0;
  bit presented = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a * 37 + 11);
  endfunction

  function automatic logic [7:0] ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] bus_rd(input int a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return init_byte(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] word);
    for (int k = 0; k < 4; k++) begin
      ref_mem[int'(a) + k] = word[k*8 +: 8];
      bus_mem[int'(a) + k] = word[k*8 +: 8];
    end
  endtask

  // Offer one op, wait (bounded) for acceptance, and predict its outcome.
  task automatic issue(input logic [1:0] op, input logic [2:0] size, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input int lat, output int xc);
    wb_t         w;
    req_t        r;
    int          n, budget;
    logic [31:0] v;
    @(negedge clk);
    ex_valid = 1'b1; ex_lsu_op = op; ex_size = size; ex_alu_res = a; ex_wdata = wd; ex_rd = rd;
    #1;
    budget = 0;
    while (!ex_ready && budget < 300) begin
      @(negedge clk); #1;
      budget++;
    end
    if (!ex_ready) begin
      check("issue_timeout", 0, 1);
      ex_valid = 1'b0;
      xc = -1;
      return;
    end
    xc = cyc;
    n = 1 << size[1:0];
    w.rd = rd; w.lat = lat; w.xc = xc; w.chk_data = 1'b1;
    w.mis = 1'b0; w.rf_we = 1'b0; w.data = '0;
    if (op != LSU_LOAD && op != LSU_STORE) begin
      w.data = a;
      w.rf_we = (rd != 0);
    end else if ((a % n) != 0 || n == 8) begin
      w.data = a;
      w.mis = 1'b1;
    end else begin
      r.addr = a & ~32'h3;
      r.we = (op == LSU_STORE);
      r.be = 4'(((1 << n) - 1) << (a % 4));
      r.wdata = '0;
      for (int i = 0; i < 4; i++) r.wdata[i*8 +: 8] = wd[(i % n)*8 +: 8];
      if (r.we) begin
        for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[k*8 +: 8];
        w.chk_data = 1'b0;
      end else begin
        v = '0;
        for (int k = 0; k < n; k++) v = v | ({24'd0, ref_rd(int'(a) + k)} << (8 * k));
        if (!size[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        w.data = v;
        w.rf_we = (rd != 0);
      end
      req_q.push_back(r);
    end
    wb_q.push_back(w);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while ((wb_q.size() != 0 || req_q.size() != 0) && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (wb_q.size() != 0 || req_q.size() != 0) check("drain_timeout", 0, 1);
  endtask

  // Memory responder: checks each request against the prediction and answers it.
  initial begin
    req_t        r;
    logic [31:0] pend_data;
    bit          pend = 0, hs;
    int          pend_cnt = 0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (dmem_rsp_valid) dmem_rsp_valid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          dmem_rsp_valid = 1'b1;
          dmem_rdata = pend_data;
          pend = 0;
        end else pend_cnt--;
      end
      if (reset) begin
        dmem_req_ready = 1'b0;
        req_stall = 0;
      end else if (dmem_req_valid) begin
        if (req_q.size() == 0) begin
          check("unexpected_req", 1, 0);
          dmem_req_ready = 1'b0;
        end else begin
          r = req_q[0];
          check("req_addr", dmem_addr, r.addr);
          check("req_we", dmem_we, r.we);
          check("req_be", dmem_be, r.be);
          if (r.we) check("req_wdata", dmem_wdata, r.wdata);
          if (req_stall < stall_req_cfg) begin
            hs = 0;
            req_stall++;
          end else hs = rand_mode ? 1'($urandom % 2) : 1'b1;
          dmem_req_ready = hs;
          if (hs) begin
            void'(req_q.pop_front());
            req_stall = 0;
            if (dmem_we) begin
              for (int i = 0; i < 4; i++)
                if (dmem_be[i]) bus_mem[int'(dmem_addr) + i] = dmem_wdata[i*8 +: 8];
              pend_data = $urandom;
            end else begin
              for (int i = 0; i < 4; i++) pend_data[i*8 +: 8] = bus_rd(int'(dmem_addr) + i);
            end
            pend = 1;
            pend_cnt = rand_mode ? int'($urandom % 3) : rsp_dly_cfg;
          end
        end
      end else dmem_req_ready = rand_mode ? 1'($urandom % 2) : 1'b0;
    end
  end

  // Writeback monitor: compares the presented result every cycle it is valid.
  initial begin
    wb_t w;
    bit  rdy;
    wb_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        wb_ready = 1'b1;
        presented = 0;
        wb_stall = 0;
      end else if (wb_valid) begin
        if (wb_q.size() == 0) begin
          check("unexpected_wb", 1, 0);
          wb_ready = 1'b1;
        end else begin
          w = wb_q[0];
          if (!presented) begin
            presented = 1;
            wb_stall = 0;
            if (w.lat >= 0) check("wb_latency", 64'(cyc - w.xc), 64'(w.lat));
          end
          check("wb_rd", wb_rd, w.rd);
          check("wb_rf_we", wb_rf_we, w.rf_we);
          check("wb_misalign", wb_misalign, w.mis);
          if (w.chk_data) check("wb_data", wb_data, w.data);
          if (wb_stall < stall_wb_cfg) begin
            rdy = 0;
            wb_stall++;
          end else rdy = rand_mode ? ($urandom % 3 != 0) : 1'b1;
          wb_ready = rdy;
          if (rdy) begin
            void'(wb_q.pop_front());
            presented = 0;
          end
        end
      end else wb_ready = rand_mode ? 1'($urandom % 2) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int xa, xb, b;
    logic [31:0] a;
    logic [1:0]  op;
    logic [2:0]  sz;
    reset = 1'b1; ex_valid = 1'b0; ex_alu_res = '0; ex_wdata = '0;
    ex_rd = '0; ex_lsu_op = '0; ex_size = '0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // Reset state.
    @(negedge clk); #1;
    check("rst_ex_ready", ex_ready, 1);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_req_valid", dmem_req_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_rf_we", wb_rf_we, 0);
    check("rst_wb_misalign", wb_misalign, 0);
    check("rst_dmem_be", dmem_be, 0);
    check("rst_dmem_addr", dmem_addr, 0);

    // Signed byte load from the top lane.
    preload(32'h1000, 32'h80FF_FFFF);
    issue(LSU_LOAD, 3'b000, 32'h1003, 32'h0, 5'd5, 3, xa);
    idle(); drain();
    // Halfword store in the upper lane.
    issue(LSU_STORE, 3'b001, 32'h2002, 32'h1234, 5'd7, 3, xa);
    idle(); drain();
    // Misaligned word load.
    issue(LSU_LOAD, 3'b010, 32'h3001, 32'h0, 5'd9, 1, xa);
    idle(); drain();
    // Dword is illegal on a 32-bit bus even when 8-byte aligned.
    issue(LSU_LOAD, 3'b011, 32'h3008, 32'h0, 5'd9, 1, xa);
    idle(); drain();
    // Plain ALU result, with and without a destination.
    issue(LSU_NONE, 3'b000, 32'hDEAD_BEEF, 32'h0, 5'd3, 1, xa);
    issue(LSU_NONE, 3'b000, 32'h1234_5678, 32'h0, 5'd0, 1, xa);
    idle(); drain();
    // Load with rd=0 still accesses memory.
    issue(LSU_LOAD, 3'b101, 32'h2002, 32'h0, 5'd0, 3, xa);
    idle(); drain();

    // Request stalled four cycles.
    stall_req_cfg = 4;
    issue(LSU_LOAD, 3'b010, 32'h1000, 32'h0, 5'd4, 7, xa);
    idle(); drain();
    stall_req_cfg = 0;

    // Writeback back-pressure followed by a zero-bubble handoff.
    stall_wb_cfg = 3;
    issue(LSU_NONE, 3'b000, 32'h0000_00AA, 32'h0, 5'd1, 1, xa);
    issue(LSU_NONE, 3'b000, 32'h0000_00BB, 32'h0, 5'd2, 1, xb);
    idle(); drain();
    stall_wb_cfg = 0;
    check("handoff_gap", 64'(xb - xa), 64'd4);

    // Reset while waiting for a response; the late response must be ignored.
    rsp_dly_cfg = 4;
    issue(LSU_LOAD, 3'b010, 32'h1004, 32'h0, 5'd6, -1, xa);
    idle();
    b = 0;
    while (req_q.size() != 0 && b < 50) begin
      @(negedge clk); #2;
      b++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    wb_q.delete();
    req_q.delete();
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    rsp_dly_cfg = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      check("post_rst_wb_valid", wb_valid, 0);
    end
    check("post_rst_ex_ready", ex_ready, 1);
    check("post_rst_req_valid", dmem_req_valid, 0);

    // Randomized traffic.
    rand_mode = 1;
    for (int t = 0; t < 200; t++) begin
      op = 2'($urandom % 3);
      sz = 3'($urandom % 8);
      a = 32'h1000 + ($urandom % 16);
      if ($urandom % 2 == 1) a = a & ~((32'd1 << sz[1:0]) - 32'd1);
      issue(op, sz, a, $urandom, 5'($urandom % 32), -1, xa);
      if ($urandom % 4 == 0) idle();
    end
    idle();
    drain();
    rand_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
